dual_hex_rx: RTL and testbench
==============================

Name: dual_hex_rx

Overview:
- Receive side of the multiplexed two-digit seven-segment bus that the display driver produces.
- Samples the 8-bit bus, demultiplexes it by the digit-select bit, and decodes each settled segment pattern back to a 4-bit nibble.
- Flags undecodable patterns and stalled multiplexing.
- Used in loopback self-test and board-level checking of the display path.

Parameters:
- SETTLE_CYCLES, 4, consecutive identical samples required before a pattern is accepted (legal range 1..255).
- TIMEOUT_CYCLES, 2_000_000, cycles without a select toggle before the bus is declared stalled (32-bit counter).

Ports:
- i_clock  in  1  system clock; all logic on the rising edge.
- i_reset_n  in  1  reset, asynchronous assert, active-low; one clock, asynchronous active-low reset.
- hex_in  in  8  bit7 = digit select (1 = num1 digit, 0 = num2 digit); bits6..0 = segments a..g, active-low.
- num1  out  4  last accepted nibble for the select=1 digit.
- num2  out  4  last accepted nibble for the select=0 digit.
- num1_valid  out  1  num1 holds a capture made since reset or since the last stall.
- num2_valid  out  1  same, for num2.
- num1_update  out  1  one-cycle pulse when num1 is written.
- num2_update  out  1  one-cycle pulse when num2 is written.
- pattern_err  out  1  one-cycle pulse when a settled pattern is undecodable.
- err_sticky  out  1  set by any pattern_err; cleared only by reset.
- stalled  out  1  high while the select timeout is active.

Behaviour:
- Reset values: all outputs 0; internal sample register 0; counters 0; state IDLE.
- Decode table, segments6..0 -> nibble:
  - 0000001=0, 1001111=1, 0010010=2, 0000110=3
  - 0000100=9, 0001000=A, 1100000=b, 0110001=C
  - 1001100=4, 0100100=5, 0100000=6, 0001111=7
  - 0000000=8, 1000010=d, 0110000=E, 0111000=F
  - Any other pattern is undecodable.
- Sampling: hex_in is registered into s every cycle. stable_cnt resets to 1 when s differs from its previous value in any bit, including select. Otherwise stable_cnt increments and saturates at SETTLE_CYCLES.
- Capture rule: a capture fires on the edge where stable_cnt reaches SETTLE_CYCLES. It fires once per stable run. A changed pattern starts a new run and allows a new capture.
- Latency: a value first present before edge e0 is sampled at e0. If SETTLE_CYCLES=N, the capture is registered at edge e0+N. From that edge, the nibble, the valid bit and the update pulse are visible for that cycle; the update pulse lasts one cycle.
- Capture action, decodable pattern: if s[7]=1, write num1, set num1_valid and pulse num1_update; else do the same for num2.
- Capture action, undecodable pattern: pulse pattern_err, set err_sticky; num and valid outputs are unchanged.
- State machine:
  - IDLE: after reset; captures suppressed so a partial first phase is discarded. -> SETTLE on the first select toggle in s.
  - SETTLE: stable_cnt < SETTLE_CYCLES. -> HELD on capture.
  - HELD: capture done for this run. -> SETTLE on any change in s.
  - Any state -> STALLED when the timeout counter reaches TIMEOUT_CYCLES.
  - STALLED: -> SETTLE on the next select toggle.
- Timeout counter: cleared on every select toggle in s; otherwise increments and saturates at TIMEOUT_CYCLES.
- Entering STALLED: stalled=1, num1_valid=num2_valid=0; num values are retained.
- In STALLED, captures and pattern errors are suppressed. On exit, stalled=0 on the same edge as the toggle is seen.
- Simultaneous events: a toggle on the same edge the timeout would be reached wins; no stall is declared. A capture and a toggle cannot coincide, because a toggle restarts the run.
- Reset mid-operation: all state is cleared asynchronously; after deassertion the block returns to IDLE and waits for a fresh toggle.

Test Plan:
- Reset with hex_in=8'h81 held -> all outputs 0, state stays IDLE, no capture for 100 cycles.
- SETTLE_CYCLES=4: drive 0_0010010 for 10 cycles, then 1_0000110 for 10 cycles, after one prior toggle -> num2=2 then num1=3. Each update pulse occurs exactly 4 edges after its sample, and both valid bits = 1.
- Glitchy phase: select=1 with 1_0100100 for 2 cycles, then 1_0001000 for 6 cycles -> single num1_update with num1=A; 5 is never captured.
- Pattern 1_1111111 held 8 cycles -> one pattern_err pulse, err_sticky=1; num1 and num1_valid unchanged.
- TIMEOUT_CYCLES=64: select held constant for 64 cycles -> stalled=1, both valid bits=0, num retained. A toggle then a settled 0_0111000 -> stalled=0, num2=F, num2_valid=1.
- Assert i_reset_n low asynchronously between clock edges during HELD -> outputs zero immediately; err_sticky cleared; first capture after release only follows a select toggle.

Source files
------------

// File: rtl/dual_hex_rx.sv
// Receiver for the multiplexed two-digit seven-segment bus: samples, demultiplexes
// by digit select, waits for a settled pattern and decodes it back to a nibble.
module dual_hex_rx #(
    parameter int unsigned SETTLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
    input  logic       i_clock,
    input  logic       i_reset_n,
    input  logic [7:0] hex_in,
    output logic [3:0] num1,
    output logic [3:0] num2,
    output logic       num1_valid,
    output logic       num2_valid,
    output logic       num1_update,
    output logic       num2_update,
    output logic       pattern_err,
    output logic       err_sticky,
    output logic       stalled,
    output logic [1:0] state
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SETTLE  = 2'd1;
    localparam logic [1:0] HELD    = 2'd2;
    localparam logic [1:0] STALLED = 2'd3;

    localparam logic [7:0]  SETTLE_MAX  = 8'(SETTLE_CYCLES);
    localparam logic [31:0] TIMEOUT_MAX = 32'(TIMEOUT_CYCLES);

    logic [7:0]  s;
    logic [7:0]  s_d;
    logic        s_ok;
    logic        s_d_ok;
    logic [7:0]  stable_cnt;
    logic [7:0]  stable_next;
    logic [31:0] tcnt;
    logic [31:0] tcnt_next;
    logic [1:0]  state_next;
    logic        changed;
    logic        toggle;
    logic        fire;
    logic        stall_hit;
    logic        capture;
    logic        dec_ok;
    logic [3:0]  dec_nib;

    always_comb begin
        dec_ok  = 1'b1;
        dec_nib = 4'h0;
        case (s[6:0])
            7'b0000001: dec_nib = 4'h0;
            7'b1001111: dec_nib = 4'h1;
            7'b0010010: dec_nib = 4'h2;
            7'b0000110: dec_nib = 4'h3;
            7'b1001100: dec_nib = 4'h4;
            7'b0100100: dec_nib = 4'h5;
            7'b0100000: dec_nib = 4'h6;
            7'b0001111: dec_nib = 4'h7;
            7'b0000000: dec_nib = 4'h8;
            7'b0000100: dec_nib = 4'h9;
            7'b0001000: dec_nib = 4'hA;
            7'b1100000: dec_nib = 4'hB;
            7'b0110001: dec_nib = 4'hC;
            7'b1000010: dec_nib = 4'hD;
            7'b0110000: dec_nib = 4'hE;
            7'b0111000: dec_nib = 4'hF;
            default:    dec_ok  = 1'b0;
        endcase
    end

    // A toggle only counts once s_d holds a real sample, so the reset value of
    // the sample register never looks like a select edge.
    always_comb begin
        changed     = (s != s_d);
        toggle      = s_d_ok && (s[7] != s_d[7]);
        stable_next = changed ? 8'd1
                    : (stable_cnt == SETTLE_MAX) ? SETTLE_MAX : stable_cnt + 8'd1;
        fire        = (stable_next == SETTLE_MAX) && (changed || stable_cnt != SETTLE_MAX);
        tcnt_next   = toggle ? 32'd0
                    : (tcnt == TIMEOUT_MAX) ? TIMEOUT_MAX : tcnt + 32'd1;
        stall_hit   = (tcnt_next == TIMEOUT_MAX);
        capture     = fire && !stall_hit && (state == SETTLE || state == HELD);
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (toggle) state_next = SETTLE;
            SETTLE:  if (fire) state_next = HELD;
            HELD:    if (fire) state_next = HELD;
                     else if (changed) state_next = SETTLE;
            STALLED: if (toggle) state_next = SETTLE;
            default: state_next = IDLE;
        endcase
        if (stall_hit) state_next = STALLED;
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            s           <= 8'h00;
            s_d         <= 8'h00;
            s_ok        <= 1'b0;
            s_d_ok      <= 1'b0;
            stable_cnt  <= 8'd0;
            tcnt        <= 32'd0;
            state       <= IDLE;
            num1        <= 4'h0;
            num2        <= 4'h0;
            num1_valid  <= 1'b0;
            num2_valid  <= 1'b0;
            num1_update <= 1'b0;
            num2_update <= 1'b0;
            pattern_err <= 1'b0;
            err_sticky  <= 1'b0;
            stalled     <= 1'b0;
        end else begin
            s           <= hex_in;
            s_d         <= s;
            s_ok        <= 1'b1;
            s_d_ok      <= s_ok;
            stable_cnt  <= stable_next;
            tcnt        <= tcnt_next;
            state       <= state_next;
            num1_update <= 1'b0;
            num2_update <= 1'b0;
            pattern_err <= 1'b0;
            stalled     <= (state_next == STALLED);
            if (stall_hit) begin
                num1_valid <= 1'b0;
                num2_valid <= 1'b0;
            end else if (capture) begin
                if (!dec_ok) begin
                    pattern_err <= 1'b1;
                    err_sticky  <= 1'b1;
                end else if (s[7]) begin
                    num1        <= dec_nib;
                    num1_valid  <= 1'b1;
                    num1_update <= 1'b1;
                end else begin
                    num2        <= dec_nib;
                    num2_valid  <= 1'b1;
                    num2_update <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_dual_hex_rx.sv
// Bench for dual_hex_rx: directed scenarios plus random bus traffic, checked every
// cycle against a run-length based model of the receiver.
module tb_dual_hex_rx;

    localparam int NSET = 4;
    localparam int TMO  = 64;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] hex_in = 8'h81;
    logic [3:0] num1, num2;
    logic       num1_valid, num2_valid, num1_update, num2_update;
    logic       pattern_err, err_sticky, stalled;
    logic [1:0] state;

    int total = 0;
    int bad   = 0;

    dual_hex_rx #(.SETTLE_CYCLES(NSET), .TIMEOUT_CYCLES(TMO)) dut (
        .i_clock     (clk),
        .i_reset_n   (rst_n),
        .hex_in      (hex_in),
        .num1        (num1),
        .num2        (num2),
        .num1_valid  (num1_valid),
        .num2_valid  (num2_valid),
        .num1_update (num1_update),
        .num2_update (num2_update),
        .pattern_err (pattern_err),
        .err_sticky  (err_sticky),
        .stalled     (stalled),
        .state       (state)
    );

    always #5 clk = ~clk;

    // Segment code for each nibble value, index = nibble.
    logic [6:0] seg_tab [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                 7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                 7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                                 7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0]  hist [$];
    int unsigned m_tcnt;
    bit          m_armed, m_stall;
    logic [3:0]  m_num1, m_num2;
    bit          m_v1, m_v2, m_u1, m_u2, m_perr, m_sticky;

    task automatic model_reset();
        hist.delete();
        m_tcnt = 0; m_armed = 0; m_stall = 0;
        m_num1 = 0; m_num2 = 0; m_v1 = 0; m_v2 = 0;
        m_u1 = 0; m_u2 = 0; m_perr = 0; m_sticky = 0;
    endtask

    task automatic model_step(input logic [7:0] x);
        bit allowed, toggle, run_done, hit, found;
        logic [7:0] v;
        logic [3:0] nib;
        int n;
        allowed  = m_armed && !m_stall;
        n        = hist.size();
        toggle   = (n >= 2) && (hist[n-1][7] != hist[n-2][7]);
        run_done = 0;
        v        = 8'h00;
        // A run of exactly NSET identical samples ending at the last sample.
        if (n >= NSET + 1) begin
            v = hist[n-1];
            run_done = (hist[n-1-NSET] != v);
            for (int i = 1; i <= NSET; i++)
                if (hist[n-i] != v) run_done = 0;
        end
        if (toggle) m_tcnt = 0;
        else if (m_tcnt < TMO) m_tcnt++;
        hit = (m_tcnt == TMO);
        m_u1 = 0; m_u2 = 0; m_perr = 0;
        if (hit) begin
            m_stall = 1; m_armed = 0; m_v1 = 0; m_v2 = 0;
        end else begin
            if (allowed && run_done) begin
                found = 0; nib = 0;
                for (int k = 0; k < 16; k++)
                    if (seg_tab[k] == v[6:0]) begin found = 1; nib = 4'(k); end
                if (!found) begin m_perr = 1; m_sticky = 1; end
                else if (v[7]) begin m_num1 = nib; m_v1 = 1; m_u1 = 1; end
                else begin m_num2 = nib; m_v2 = 1; m_u2 = 1; end
            end
            if (toggle) begin m_stall = 0; m_armed = 1; end
        end
        hist.push_back(x);
        if (hist.size() > NSET + 2) void'(hist.pop_front());
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else model_step(hex_in);
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("num1", num1, m_num1);
            chk("num2", num2, m_num2);
            chk("num1_valid", num1_valid, m_v1);
            chk("num2_valid", num2_valid, m_v2);
            chk("num1_update", num1_update, m_u1);
            chk("num2_update", num2_update, m_u2);
            chk("pattern_err", pattern_err, m_perr);
            chk("err_sticky", err_sticky, m_sticky);
            chk("stalled", stalled, m_stall);
        end
    end

    // ---------------- driver helpers ----------------
    task automatic drive(input logic [7:0] x, input int n);
        for (int i = 0; i < n; i++) begin
            hex_in = x;
            @(posedge clk); #1;
        end
    endtask

    function automatic logic [8:0] outs_word();
        return {num1, num2, num1_valid, num2_valid, num1_update, num2_update,
                pattern_err, err_sticky, stalled} == 0 ? 9'd0 : 9'd1;
    endfunction

    initial begin
        int cnt;
        logic [7:0] x;
        int len;

        // Reset with 8'h81 held.
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {23'd0, outs_word()}, 0);
        chk("reset_state", state, 2'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 100; i++) begin
            chk("idle_no_update", {num1_update, num2_update}, 2'b00);
            if (i < 60) begin
                chk("idle_outputs", {23'd0, outs_word()}, 0);
                chk("idle_state", state, 2'd0);
            end
            @(posedge clk); #1;
        end

        // Settled digits, pulse four edges after the sample.
        for (int i = 0; i < 10; i++) begin
            hex_in = 8'h12;
            @(posedge clk); #1;
            chk("num2_update_timing", num2_update, (i == 4));
        end
        chk("num2_is_2", num2, 4'h2);
        chk("model_num2_is_2", m_num2, 4'h2);
        for (int i = 0; i < 10; i++) begin
            hex_in = 8'h86;
            @(posedge clk); #1;
            chk("num1_update_timing", num1_update, (i == 4));
        end
        chk("num1_is_3", num1, 4'h3);
        chk("both_valid", {num1_valid, num2_valid}, 2'b11);
        chk("model_num1_is_3", m_num1, 4'h3);

        // Glitchy phase: 5 must never be captured, A captured once.
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            hex_in = (i < 2) ? 8'hA4 : 8'h88;
            @(posedge clk); #1;
            cnt += int'(num1_update);
            chk("num1_never_5", num1 == 4'h5, 0);
        end
        chk("glitch_one_update", cnt, 1);
        chk("num1_is_A", num1, 4'hA);

        // Undecodable pattern.
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            hex_in = 8'hFF;
            @(posedge clk); #1;
            cnt += int'(pattern_err);
        end
        chk("one_pattern_err", cnt, 1);
        chk("err_sticky_set", err_sticky, 1);
        chk("num1_kept_A", num1, 4'hA);
        chk("num1_valid_kept", num1_valid, 1);
        chk("model_sticky", m_sticky, 1);

        // Stall: select constant long enough to time out.
        drive(8'hFF, 50);
        chk("stalled_set", stalled, 1);
        chk("stall_state", state, 2'd3);
        chk("stall_valids", {num1_valid, num2_valid}, 2'b00);
        chk("stall_num_kept", {num1, num2}, 8'hA2);
        for (int i = 0; i < 8; i++) begin
            hex_in = 8'h38;
            @(posedge clk); #1;
            if (i == 0) chk("stall_before_toggle_seen", stalled, 1);
            if (i == 1) chk("stall_exit", stalled, 0);
        end
        chk("num2_is_F", num2, 4'hF);
        chk("num2_valid_after_stall", num2_valid, 1);
        chk("num1_valid_after_stall", num1_valid, 0);

        // Random traffic.
        for (int r = 0; r < 300; r++) begin
            x[7] = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) x[6:0] = 7'($urandom_range(0, 127));
            else x[6:0] = seg_tab[$urandom_range(0, 15)];
            if ($urandom_range(0, 24) == 0) len = $urandom_range(60, 80);
            else len = $urandom_range(1, 8);
            drive(x, len);
        end

        // Asynchronous reset while HELD with err_sticky set.
        drive(8'hCF, 8);
        drive(8'h7F, 8);
        drive(8'h01, 8);
        chk("pre_reset_sticky", err_sticky, 1);
        chk("pre_reset_held", state, 2'd2);
        #3 rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", {23'd0, outs_word()}, 0);
        chk("async_reset_state", state, 2'd0);
        hex_in = 8'h06;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 20; i++) begin
            chk("post_reset_no_capture", {num1_update, num2_update}, 2'b00);
            chk("post_reset_idle", state, 2'd0);
            @(posedge clk); #1;
        end
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            hex_in = 8'hCF;
            @(posedge clk); #1;
            cnt += int'(num1_update);
        end
        chk("post_reset_capture", cnt, 1);
        chk("post_reset_num1", num1, 4'h1);
        chk("post_reset_num2_invalid", num2_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
